// File: rtl/y86_pkg.sv
// Shared Y86 definitions: status codes, register IDs, icodes, the
// writeback state enum, the W-entry bundle and a destination check.
package y86_pkg;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] IHALT = 4'h0;
    localparam logic [3:0] INOP  = 4'h1;

    typedef enum logic [1:0] {
        WB_RUN,
        WB_HALT,
        WB_ERR
    } wb_state_e;

    typedef struct packed {
        logic        valid;
        logic        done;
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [31:0] vale;
        logic [31:0] valm;
        logic [3:0]  dste;
        logic [3:0]  dstm;
    } w_entry_t;

    // IDs 8..14 are not real registers and never get written.
    function automatic logic dst_ok(input logic [3:0] id,
                                    input logic [3:0] rnone);
        return (id < 4'd8 || id > 4'd14) && id != rnone;
    endfunction

endpackage

// File: rtl/wb_perf_cnt.sv
// Writeback performance counters (retired entries, bubble cycles).
// Ports: clock, reset (sync, active-high), inc_ret, inc_bub -> retired, bubbles.
module wb_perf_cnt (
    input  logic        clock,
    input  logic        reset,
    input  logic        inc_ret,
    input  logic        inc_bub,
    output logic [31:0] retired,
    output logic [31:0] bubbles
);

    // Both counters wrap naturally at 2^32.
    always_ff @(posedge clock) begin
        if (reset) begin
            retired <= '0;
            bubbles <= '0;
        end else begin
            if (inc_ret)
                retired <= retired + 32'd1;
            if (inc_bub)
                bubbles <= bubbles + 32'd1;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Y86 writeback stage: holds the W entry, drives the register-file write
// ports, tracks RUN/HALT/ERR and the last retired status.
// Ports: clock, reset (sync, active-high); m_* handshake and entry fields
// from memory; stall/bubble from hazard control; dstE/valE/dstM/valM write
// ports; w_stat, halted; retired/bubbles counters (present only when
// WB_PERF_CNT_EN is defined, otherwise constant 0).
module wb_stage #(
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m_valid,
    output logic        m_ready,
    input  logic [2:0]  m_stat,
    input  logic [3:0]  m_icode,
    input  logic [31:0] m_valE,
    input  logic [31:0] m_valM,
    input  logic [3:0]  m_dstE,
    input  logic [3:0]  m_dstM,
    input  logic        stall,
    input  logic        bubble,
    output logic [3:0]  dstE,
    output logic [31:0] valE,
    output logic [3:0]  dstM,
    output logic [31:0] valM,
    output logic [2:0]  w_stat,
    output logic        halted,
    output logic [31:0] retired,
    output logic [31:0] bubbles
);

    import y86_pkg::*;

    wb_state_e state, state_nx;
    w_entry_t  w, w_nx;
    logic [2:0] last_stat;
    logic       xfer;
    logic       pres;
    logic       wr_ok;
    logic       icode_unused;

    assign m_ready = (state == WB_RUN) && !stall;
    assign xfer    = m_valid && m_ready;

    // Entry is live on the write ports only on its first RUN cycle; the
    // reset term keeps the reset cycle itself write-free.
    assign pres  = w.valid && !w.done && (state == WB_RUN) && !reset;
    assign wr_ok = pres && (w.stat == SAOK);

    // icode is carried for visibility in the pipeline only.
    assign icode_unused = ^w.icode;

    always_comb begin
        w_nx = w;
        if (stall) begin
            w_nx.done = 1'b1;
        end else if (xfer) begin
            w_nx.valid = 1'b1;
            w_nx.done  = 1'b0;
            w_nx.stat  = m_stat;
            w_nx.icode = m_icode;
            w_nx.vale  = m_valE;
            w_nx.valm  = m_valM;
            w_nx.dste  = m_dstE;
            w_nx.dstm  = m_dstM;
        end else begin
            w_nx.valid = 1'b0;
            w_nx.done  = 1'b0;
            if (bubble) begin
                w_nx.dste = RNONE;
                w_nx.dstm = RNONE;
            end
        end
    end

    always_comb begin
        state_nx = state;
        if (state == WB_RUN && pres) begin
            if (w.stat == SHLT)
                state_nx = WB_HALT;
            else if (w.stat == SADR || w.stat == SINS)
                state_nx = WB_ERR;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= WB_RUN;
            w.valid   <= 1'b0;
            w.done    <= 1'b0;
            w.stat    <= SAOK;
            w.icode   <= '0;
            w.vale    <= '0;
            w.valm    <= '0;
            w.dste    <= RNONE;
            w.dstm    <= RNONE;
            last_stat <= SAOK;
        end else begin
            state <= state_nx;
            w     <= w_nx;
            if (pres)
                last_stat <= w.stat;
        end
    end

    // When both ports target the same register the memory value wins.
    assign dstM = (wr_ok && dst_ok(w.dstm, RNONE)) ? w.dstm : RNONE;
    assign dstE = (wr_ok && dst_ok(w.dste, RNONE) && w.dste != w.dstm)
                  ? w.dste : RNONE;
    assign valE = w.vale;
    assign valM = w.valm;

    assign w_stat = pres ? w.stat : last_stat;
    assign halted = (state != WB_RUN);

`ifdef WB_PERF_CNT_EN
    logic inc_ret;
    logic inc_bub;

    assign inc_ret = pres && (w.stat == SAOK || w.stat == SHLT);
    assign inc_bub = !w.valid && (state == WB_RUN);

    wb_perf_cnt u_perf (
        .clock   (clock),
        .reset   (reset),
        .inc_ret (inc_ret),
        .inc_bub (inc_bub),
        .retired (retired),
        .bubbles (bubbles)
    );
`else
    assign retired = '0;
    assign bubbles = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus random traffic
// compared each cycle against a behavioural model of the stage.
module tb_wb_stage;

`ifdef WB_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        m_valid;
    logic        m_ready;
    logic [2:0]  m_stat;
    logic [3:0]  m_icode;
    logic [31:0] m_valE;
    logic [31:0] m_valM;
    logic [3:0]  m_dstE;
    logic [3:0]  m_dstM;
    logic        stall;
    logic        bubble;
    logic [3:0]  dstE;
    logic [31:0] valE;
    logic [3:0]  dstM;
    logic [31:0] valM;
    logic [2:0]  w_stat;
    logic        halted;
    logic [31:0] retired;
    logic [31:0] bubbles;

    int n_total = 0;
    int n_bad   = 0;

    // behavioural model: one held result plus status/counter bookkeeping
    bit          mv;
    bit          mdone;
    int          mst;      // 0 running, 1 halted, 2 error
    logic [2:0]  mstat;
    logic [2:0]  mlast;
    logic [3:0]  mde;
    logic [3:0]  mdm;
    logic [31:0] mve;
    logic [31:0] mvm;
    logic [31:0] mret;
    logic [31:0] mbub;

    wb_stage dut (
        .clock   (clock),
        .reset   (reset),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_stat  (m_stat),
        .m_icode (m_icode),
        .m_valE  (m_valE),
        .m_valM  (m_valM),
        .m_dstE  (m_dstE),
        .m_dstM  (m_dstM),
        .stall   (stall),
        .bubble  (bubble),
        .dstE    (dstE),
        .valE    (valE),
        .dstM    (dstM),
        .valM    (valM),
        .w_stat  (w_stat),
        .halted  (halted),
        .retired (retired),
        .bubbles (bubbles)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mreset();
        mv    = 0;
        mdone = 0;
        mst   = 0;
        mstat = 3'd1;
        mlast = 3'd1;
        mde   = 4'hF;
        mdm   = 4'hF;
        mve   = 0;
        mvm   = 0;
        mret  = 0;
        mbub  = 0;
    endtask

    task automatic idle_inputs();
        m_valid = 0;
        stall   = 0;
        bubble  = 0;
        m_stat  = 3'd1;
        m_icode = 4'h1;
        m_valE  = 0;
        m_valM  = 0;
        m_dstE  = 4'hF;
        m_dstM  = 4'hF;
    endtask

    // Called at a falling edge: compare, advance model over the rising
    // edge, return at the next falling edge.
    task automatic cyc();
        bit p;
        int nst;
        #1;
        p = mv && !mdone && mst == 0 && !reset;
        chk("m_ready", {31'd0, m_ready}, {31'd0, (mst == 0 && !stall)});
        chk("dstE", {28'd0, dstE},
            {28'd0, (p && mstat == 1 && mde < 8 && mde != mdm) ? mde : 4'hF});
        chk("dstM", {28'd0, dstM},
            {28'd0, (p && mstat == 1 && mdm < 8) ? mdm : 4'hF});
        chk("valE", valE, mve);
        chk("valM", valM, mvm);
        chk("w_stat", {29'd0, w_stat}, {29'd0, p ? mstat : mlast});
        chk("halted", {31'd0, halted}, {31'd0, mst != 0});
        chk("retired", retired, PERF ? mret : 32'd0);
        chk("bubbles", bubbles, PERF ? mbub : 32'd0);
        @(posedge clock);
        if (reset) begin
            mreset();
        end else begin
            nst = mst;
            if (p) begin
                mlast = mstat;
                if (mstat == 1 || mstat == 2) mret = mret + 1;
                if (mstat == 2) nst = 1;
                else if (mstat == 3 || mstat == 4) nst = 2;
            end
            if (mst == 0 && !mv) mbub = mbub + 1;
            if (stall) begin
                mdone = 1;
            end else if (m_valid && mst == 0) begin
                mv    = 1;
                mdone = 0;
                mstat = m_stat;
                mve   = m_valE;
                mvm   = m_valM;
                mde   = m_dstE;
                mdm   = m_dstM;
            end else begin
                mv    = 0;
                mdone = 0;
                if (bubble) begin
                    mde = 4'hF;
                    mdm = 4'hF;
                end
            end
            mst = nst;
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        cyc();
        reset = 0;
    endtask

    task automatic offer(input logic [2:0] st, input logic [3:0] de,
                         input logic [31:0] ve, input logic [3:0] dm,
                         input logic [31:0] vm);
        m_valid = 1;
        m_stat  = st;
        m_dstE  = de;
        m_valE  = ve;
        m_dstM  = dm;
        m_valM  = vm;
        cyc();
        m_valid = 0;
    endtask

    initial begin
        mreset();
        idle_inputs();
        reset = 1;
        @(posedge clock);
        @(negedge clock);
        reset = 0;
        #1;
        chk("rst_dstE", {28'd0, dstE}, 32'hF);
        chk("rst_dstM", {28'd0, dstM}, 32'hF);
        chk("rst_valE", valE, 32'd0);
        chk("rst_wstat", {29'd0, w_stat}, 32'd1);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_ready", {31'd0, m_ready}, 32'd1);
        chk("rst_retired", retired, 32'd0);
        cyc();

        // plain accept, one-cycle write latency
        do_reset();
        offer(3'd1, 4'd2, 32'h12345678, 4'hF, 32'd0);
        #1;
        chk("acc_dstE", {28'd0, dstE}, 32'd2);
        chk("acc_valE", valE, 32'h12345678);
        chk("acc_dstM", {28'd0, dstM}, 32'hF);
        cyc();
        #1;
        chk("acc_dstE_gone", {28'd0, dstE}, 32'hF);
        chk("acc_retired", retired, PERF ? 32'd1 : 32'd0);
        cyc();

        // stall holds entry but writes only once
        offer(3'd1, 4'd3, 32'h55, 4'hF, 32'd0);
        stall = 1;
        #1;
        chk("stl_dstE0", {28'd0, dstE}, 32'd3);
        chk("stl_ready0", {31'd0, m_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            chk("stl_dstE", {28'd0, dstE}, 32'hF);
            chk("stl_ready", {31'd0, m_ready}, 32'd0);
        end
        stall = 0;
        cyc();

        // same destination on both ports
        offer(3'd1, 4'd5, 32'hA, 4'd5, 32'hB);
        #1;
        chk("dup_dstE", {28'd0, dstE}, 32'hF);
        chk("dup_dstM", {28'd0, dstM}, 32'd5);
        chk("dup_valM", valM, 32'hB);
        cyc();

        // halt: no write, absorbing
        offer(3'd2, 4'd1, 32'h9, 4'hF, 32'd0);
        #1;
        chk("hlt_dstE", {28'd0, dstE}, 32'hF);
        cyc();
        #1;
        chk("hlt_halted", {31'd0, halted}, 32'd1);
        chk("hlt_ready", {31'd0, m_ready}, 32'd0);
        m_valid = 1;
        m_stat  = 3'd1;
        m_dstE  = 4'd4;
        for (int i = 0; i < 3; i++) cyc();
        #1;
        chk("hlt_ignored", {28'd0, dstE}, 32'hF);
        m_valid = 0;

        // address error, then reset recovery
        do_reset();
        offer(3'd3, 4'd6, 32'h1, 4'hF, 32'd0);
        #1;
        chk("adr_wstat", {29'd0, w_stat}, 32'd3);
        cyc();
        #1;
        chk("adr_halted", {31'd0, halted}, 32'd1);
        chk("adr_wstat_hold", {29'd0, w_stat}, 32'd3);
        do_reset();
        #1;
        chk("adr_rst_halted", {31'd0, halted}, 32'd0);
        chk("adr_rst_wstat", {29'd0, w_stat}, 32'd1);
        chk("adr_rst_ready", {31'd0, m_ready}, 32'd1);

        // bubbles for four cycles right after reset
        bubble = 1;
        for (int i = 0; i < 4; i++) cyc();
        #1;
        chk("bub_dstE", {28'd0, dstE}, 32'hF);
        chk("bub_dstM", {28'd0, dstM}, 32'hF);
        chk("bub_count", bubbles, PERF ? 32'd4 : 32'd0);
        bubble = 0;

        // random traffic against the model
        for (int i = 0; i < 800; i++) begin
            reset   = ($urandom_range(0, 49) == 0) ||
                      (mst != 0 && $urandom_range(0, 7) == 0);
            m_valid = ($urandom_range(0, 9) < 6);
            stall   = ($urandom_range(0, 9) < 2);
            bubble  = !m_valid && ($urandom_range(0, 9) < 3);
            m_stat  = ($urandom_range(0, 99) < 90)
                      ? 3'd1 : 3'($urandom_range(2, 4));
            m_icode = 4'($urandom_range(0, 15));
            m_dstE  = 4'($urandom_range(0, 15));
            m_dstM  = ($urandom_range(0, 3) == 0)
                      ? m_dstE : 4'($urandom_range(0, 15));
            m_valE  = $urandom;
            m_valM  = $urandom;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
